// File: rtl/huff_pkg.sv
// rtl/huff_pkg.sv - shared constants, FSM states and helpers for the canonical Huffman code assigner
package huff_pkg;

  localparam int MAX_LEN = 15;
  localparam int LEN_BIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_NEXT,
    ST_EMIT,
    ST_DONE
  } state_t;

  // Lengths above MAX_LEN mark the symbol as unused.
  function automatic logic [LEN_BIT-1:0] clamp_len(input logic [LEN_BIT-1:0] len);
    return (int'(len) > MAX_LEN) ? '0 : len;
  endfunction

  // Reverses the low len bits of a right-aligned code; upper bits come back zero.
  function automatic logic [MAX_LEN-1:0] bit_rev(input logic [MAX_LEN-1:0] code,
                                                 input logic [LEN_BIT-1:0] len);
    logic [MAX_LEN-1:0] rev;
    rev = {<<{code}};
    return rev >> (MAX_LEN - int'(len));
  endfunction

endpackage

// File: rtl/huff_bl_count.sv
// rtl/huff_bl_count.sv - per-length code count histogram with sync clear and step-indexed reads
module huff_bl_count
  import huff_pkg::*;
#(
  parameter int COUNT_BIT = 9
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_inc,
  input  logic [LEN_BIT-1:0]   i_inc_len,
  input  logic [LEN_BIT-1:0]   i_rd_step,
  output logic [COUNT_BIT-1:0] o_cnt,
  output logic [COUNT_BIT-1:0] o_cnt_prev
);

  logic [COUNT_BIT-1:0] r_cnt [0:MAX_LEN];

  // Entry 0 is never incremented, so it reads as the zero the recurrence expects.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i <= MAX_LEN; i++) r_cnt[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i <= MAX_LEN; i++) r_cnt[i] <= '0;
    end else if (i_inc && (i_inc_len != '0)) begin
      r_cnt[i_inc_len] <= r_cnt[i_inc_len] + 1'b1;
    end
  end

  assign o_cnt      = r_cnt[i_rd_step];
  assign o_cnt_prev = (i_rd_step == '0) ? '0 : r_cnt[i_rd_step - 1'b1];

endmodule

// File: rtl/huff_code_assign.sv
// rtl/huff_code_assign.sv - canonical Huffman code assigner: length load, next-code recurrence, code emit
// Define HUFF_BITREV_EN to emit codes bit-reversed (LSB-first) instead of MSB-first.
module huff_code_assign
  import huff_pkg::*;
#(
  parameter int SYM_BIT   = 9,
  parameter int COUNT_BIT = 9
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [SYM_BIT-1:0] num_sym,
  input  logic               len_valid,
  output logic               len_ready,
  input  logic [LEN_BIT-1:0] len_data,
  output logic               code_valid,
  input  logic               code_ready,
  output logic [SYM_BIT-1:0] code_sym,
  output logic [LEN_BIT-1:0] code_len,
  output logic [MAX_LEN-1:0] code_out,
  output logic               busy,
  output logic               done,
  output logic               err_oversub
);

  localparam int SUM_BIT = MAX_LEN + 2;

  state_t             r_state;
  logic [SYM_BIT-1:0] r_num_sym;
  logic [SYM_BIT-1:0] r_idx;
  logic [LEN_BIT-1:0] r_step;
  logic [SUM_BIT-1:0] r_code;
  logic [MAX_LEN-1:0] r_next_code [1:MAX_LEN];
  logic [LEN_BIT-1:0] r_lens [0:(1<<SYM_BIT)-1];
  logic               r_len_ready;
  logic               r_code_valid;
  logic [SYM_BIT-1:0] r_code_sym;
  logic [LEN_BIT-1:0] r_code_len;
  logic [MAX_LEN-1:0] r_code_out;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic                 w_len_fire;
  logic [LEN_BIT-1:0]   w_len_in;
  logic                 w_last;
  logic                 w_hist_clr;
  logic [COUNT_BIT-1:0] w_cnt;
  logic [COUNT_BIT-1:0] w_cnt_prev;
  logic [SUM_BIT-1:0]   w_c;
  logic                 w_over;
  logic [LEN_BIT-1:0]   w_cur_len;
  logic [MAX_LEN-1:0]   w_cur_code;

  assign w_len_fire = r_len_ready & len_valid;
  assign w_len_in   = clamp_len(len_data);
  assign w_last     = (r_idx == r_num_sym - 1'b1);
  assign w_hist_clr = (r_state == ST_IDLE) & start;
  assign w_c        = (r_code + SUM_BIT'(w_cnt_prev)) << 1;
  assign w_over     = (w_c + SUM_BIT'(w_cnt)) > (SUM_BIT'(1) << r_step);
  assign w_cur_len  = r_lens[r_idx];
  assign w_cur_code = r_next_code[w_cur_len];

  huff_bl_count #(
    .COUNT_BIT (COUNT_BIT)
  ) u_bl_count (
    .i_clk      (clock),
    .i_rst_n    (reset),
    .i_clr      (w_hist_clr),
    .i_inc      (w_len_fire),
    .i_inc_len  (w_len_in),
    .i_rd_step  (r_step),
    .o_cnt      (w_cnt),
    .o_cnt_prev (w_cnt_prev)
  );

  always_ff @(posedge clock) begin
    if (w_len_fire) r_lens[r_idx] <= w_len_in;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_num_sym    <= '0;
      r_idx        <= '0;
      r_step       <= '0;
      r_code       <= '0;
      r_len_ready  <= 1'b0;
      r_code_valid <= 1'b0;
      r_code_sym   <= '0;
      r_code_len   <= '0;
      r_code_out   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      for (int i = 1; i <= MAX_LEN; i++) r_next_code[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_num_sym <= num_sym;
            r_busy    <= 1'b1;
            if (num_sym == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= ST_LOAD;
              r_len_ready <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (w_len_fire) begin
            if (w_last) begin
              r_len_ready <= 1'b0;
              r_state     <= ST_NEXT;
              r_step      <= LEN_BIT'(1);
              r_code      <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        ST_NEXT: begin
          r_next_code[r_step] <= w_c[MAX_LEN-1:0];
          r_code              <= w_c;
          if (w_over) r_err <= 1'b1;
          if (r_step == LEN_BIT'(MAX_LEN)) begin
            r_step <= '0;
            r_idx  <= '0;
            if (r_err || w_over) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_EMIT;
            end
          end else begin
            r_step <= r_step + 1'b1;
          end
        end
        ST_EMIT: begin
          // Each coded symbol takes a load cycle then holds until its handshake.
          if (r_code_valid) begin
            if (code_ready) begin
              r_code_valid             <= 1'b0;
              r_next_code[r_code_len] <= r_next_code[r_code_len] + 1'b1;
              if (w_last) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
          end else if (w_cur_len == '0) begin
            if (w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_code_valid <= 1'b1;
            r_code_sym   <= r_idx;
            r_code_len   <= w_cur_len;
`ifdef HUFF_BITREV_EN
            r_code_out   <= bit_rev(w_cur_code, w_cur_len);
`else
            r_code_out   <= w_cur_code;
`endif
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign len_ready   = r_len_ready;
  assign code_valid  = r_code_valid;
  assign code_sym    = r_code_sym;
  assign code_len    = r_code_len;
  assign code_out    = r_code_out;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err_oversub = r_err;

endmodule

// File: tb/tb_huff_code_assign.sv
// tb/tb_huff_code_assign.sv - directed self-checking bench for huff_code_assign
module tb_huff_code_assign;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  num_sym = '0;
  logic        len_valid = 1'b0;
  logic        len_ready;
  logic [3:0]  len_data = '0;
  logic        code_valid;
  logic        code_ready = 1'b0;
  logic [8:0]  code_sym;
  logic [3:0]  code_len;
  logic [14:0] code_out;
  logic        busy;
  logic        done;
  logic        err_oversub;

  int n_checks = 0;
  int n_err    = 0;

  int stim     [0:7];
  int exp_sym  [0:7];
  int exp_len  [0:7];
  int exp_code [0:7];
  int exp_n;
  int got_sym  [0:7];
  int got_len  [0:7];
  int got_code [0:7];
  int got_n;
  bit got_done;
  int first_valid;
  int n_valid_seen;
  logic lr_after;
  logic err_c0;
  logic err_c1;

  huff_code_assign dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .num_sym     (num_sym),
    .len_valid   (len_valid),
    .len_ready   (len_ready),
    .len_data    (len_data),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .code_sym    (code_sym),
    .code_len    (code_len),
    .code_out    (code_out),
    .busy        (busy),
    .done        (done),
    .err_oversub (err_oversub)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_build(input int n);
    @(posedge clock); #1;
    start   = 1'b1;
    num_sym = 9'(n);
    @(posedge clock); #1;
    start   = 1'b0;
  endtask

  task automatic send_lens(input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      len_valid = 1'b1;
      len_data  = 4'(stim[k]);
      t = 0;
      @(negedge clock);
      while (!len_ready && t < 50) begin
        @(negedge clock);
        t++;
      end
      if (t >= 50) chk("len_ready_timeout", len_ready, 1);
      @(posedge clock); #1;
    end
    len_valid = 1'b0;
    len_data  = '0;
  endtask

  task automatic collect(input bit toggle, input int limit);
    logic [8:0]  h_sym;
    logic [3:0]  h_len;
    logic [14:0] h_code;
    bit stalled;
    got_n = 0; got_done = 0; first_valid = -1; n_valid_seen = 0; stalled = 0;
    h_sym = '0; h_len = '0; h_code = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      code_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      @(negedge clock);
      if (cyc == 0) begin
        lr_after = len_ready;
        err_c0   = err_oversub;
      end
      if (cyc == 1) err_c1 = err_oversub;
      if (done) begin
        got_done = 1;
        break;
      end
      if (code_valid) begin
        n_valid_seen++;
        if (first_valid < 0) first_valid = cyc;
        if (stalled) begin
          chk("stall_sym", code_sym, h_sym);
          chk("stall_len", code_len, h_len);
          chk("stall_code", code_out, h_code);
        end
        if (code_ready) begin
          if (got_n < 8) begin
            got_sym[got_n]  = int'(code_sym);
            got_len[got_n]  = int'(code_len);
            got_code[got_n] = int'(code_out);
          end
          got_n++;
          stalled = 0;
        end else begin
          stalled = 1;
          h_sym = code_sym; h_len = code_len; h_code = code_out;
        end
      end
      @(posedge clock); #1;
      if (limit > 0 && got_n == limit) break;
    end
    code_ready = 1'b0;
  endtask

  task automatic verify(input string tag);
    chk({tag, "_done"}, got_done, 1);
    chk({tag, "_nbeats"}, got_n, exp_n);
    for (int i = 0; i < exp_n; i++) begin
      chk({tag, "_sym"}, got_sym[i], exp_sym[i]);
      chk({tag, "_len"}, got_len[i], exp_len[i]);
      chk({tag, "_code"}, got_code[i], exp_code[i]);
    end
    chk({tag, "_err"}, err_oversub, 0);
  endtask

  task automatic setup_case1();
    stim    = '{3, 3, 3, 3, 3, 2, 4, 4};
    exp_sym = '{0, 1, 2, 3, 4, 5, 6, 7};
    exp_len = '{3, 3, 3, 3, 3, 2, 4, 4};
`ifdef HUFF_BITREV_EN
    exp_code = '{2, 6, 1, 5, 3, 0, 7, 15};
`else
    exp_code = '{2, 3, 4, 5, 6, 0, 14, 15};
`endif
    exp_n = 8;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_len_ready"}, len_ready, 0);
    chk({tag, "_code_valid"}, code_valid, 0);
    chk({tag, "_code_sym"}, code_sym, 0);
    chk({tag, "_code_len"}, code_len, 0);
    chk({tag, "_code_out"}, code_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err_oversub, 0);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    #20;
    @(posedge clock); #1;
    reset = 1'b1;

    // Case 1: mixed lengths, always ready.
    setup_case1();
    start_build(8);
    @(negedge clock);
    chk("c1_len_ready_latency", len_ready, 1);
    chk("c1_busy", busy, 1);
    @(posedge clock); #1;
    send_lens(8);
    collect(1'b0, 0);
    chk("c1_len_ready_drop", lr_after, 0);
    chk("c1_latency", (first_valid >= 16), 1);
    verify("c1");

    // Case 2: unused symbols are skipped.
    stim     = '{0, 1, 0, 1, 0, 0, 0, 0};
    exp_sym  = '{1, 3, 0, 0, 0, 0, 0, 0};
    exp_len  = '{1, 1, 0, 0, 0, 0, 0, 0};
    exp_code = '{0, 1, 0, 0, 0, 0, 0, 0};
    exp_n    = 2;
    start_build(4);
    send_lens(4);
    collect(1'b0, 0);
    chk("c2_valid_count", n_valid_seen, 2);
    verify("c2");

    // Case 3: oversubscribed at length 1.
    stim = '{1, 1, 1, 0, 0, 0, 0, 0};
    start_build(3);
    send_lens(3);
    collect(1'b0, 0);
    chk("c3_err_s1_before", err_c0, 0);
    chk("c3_err_s1_after", err_c1, 1);
    chk("c3_done", got_done, 1);
    chk("c3_no_valid", n_valid_seen, 0);
    chk("c3_err", err_oversub, 1);
    @(negedge clock);
    chk("c3_err_held", err_oversub, 1);
    chk("c3_idle_busy", busy, 0);

    // Case 4: case 1 with code_ready toggling.
    setup_case1();
    start_build(8);
    send_lens(8);
    collect(1'b1, 0);
    verify("c4");

    // Zero-symbol build goes straight to DONE.
    start_build(0);
    @(negedge clock);
    chk("z_done", done, 1);
    chk("z_busy", busy, 1);
    chk("z_len_ready", len_ready, 0);
    @(negedge clock);
    chk("z_done_pulse", done, 0);
    chk("z_busy_idle", busy, 0);

    // Case 5: reset mid-emit, then a full rebuild.
    setup_case1();
    start_build(8);
    send_lens(8);
    collect(1'b0, 3);
    chk("c5_three_beats", got_n, 3);
    reset = 1'b0;
    #1;
    check_all_zero("c5_reset");
    #10;
    @(posedge clock); #1;
    reset = 1'b1;
    start_build(8);
    send_lens(8);
    collect(1'b0, 0);
    verify("c5");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
